// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for a 5-stage in-order pipeline.
// Shadows the destination/control fields of EX, MEM and WB so that only the
// decoded ID-stage fields are needed. Produces the WB->ID regfile bypass
// selects, the EX-stage forwarding selects, the load-use stall/bubble and a
// saturating count of stall cycles. All hazard outputs are combinational and
// forced low while rst_n is asserted.
module hazard_ctrl_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_wr,
  input  logic                  id_is_load,
  input  logic                  flush,
  output logic                  stall_if_id,
  output logic                  bubble_ex,
  output logic                  mux_Sel_RAW_ID_rs1,
  output logic                  mux_Sel_RAW_ID_rs2,
  output logic [1:0]            fwd_ex_rs1,
  output logic [1:0]            fwd_ex_rs2,
  output logic [CNT_W-1:0]      stall_count
);

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

  // EX shadow
  logic                  ex_v, ex_wr, ex_ld, ex_u1, ex_u2;
  logic [REG_ADDR_W-1:0] ex_rd, ex_rs1, ex_rs2;
  // MEM shadow
  logic                  mem_v, mem_wr, mem_ld;
  logic [REG_ADDR_W-1:0] mem_rd;
  // WB shadow
  logic                  wb_v, wb_wr;
  logic [REG_ADDR_W-1:0] wb_rd;

  logic       luh, stall_int, bubble_int, raw1_int, raw2_int;
  logic [1:0] fwd1_int, fwd2_int;

  // A stage produces register r only when it is live, writes, and r is not x0.
  function automatic logic writes(input logic v, input logic wr,
                                  input logic [REG_ADDR_W-1:0] rd,
                                  input logic [REG_ADDR_W-1:0] r);
    return v & wr & (rd != '0) & (rd == r);
  endfunction

  // MEM beats WB because it holds the younger value; a load in MEM has no
  // data yet, so it yields no forward at all (the load-use stall prevents it).
  function automatic logic [1:0] fwd_sel(input logic u,
                                         input logic [REG_ADDR_W-1:0] rs,
                                         input logic m_v, input logic m_wr,
                                         input logic m_ld,
                                         input logic [REG_ADDR_W-1:0] m_rd,
                                         input logic w_v, input logic w_wr,
                                         input logic [REG_ADDR_W-1:0] w_rd);
    if (u && writes(m_v, m_wr, m_rd, rs))
      return m_ld ? FWD_NONE : FWD_MEM;
    else if (u && writes(w_v, w_wr, w_rd, rs))
      return FWD_WB;
    else
      return FWD_NONE;
  endfunction

  // Hazard detection and select generation from shadow state and ID fields.
  always_comb begin
    luh = id_valid & ex_v & ex_wr & ex_ld & (ex_rd != '0) &
          ((id_use_rs1 & (ex_rd == id_rs1)) | (id_use_rs2 & (ex_rd == id_rs2)));
    stall_int  = luh & ~flush;
    bubble_int = luh | flush;
    raw1_int   = id_valid & id_use_rs1 & writes(wb_v, wb_wr, wb_rd, id_rs1);
    raw2_int   = id_valid & id_use_rs2 & writes(wb_v, wb_wr, wb_rd, id_rs2);
    fwd1_int   = fwd_sel(ex_u1, ex_rs1, mem_v, mem_wr, mem_ld, mem_rd,
                         wb_v, wb_wr, wb_rd);
    fwd2_int   = fwd_sel(ex_u2, ex_rs2, mem_v, mem_wr, mem_ld, mem_rd,
                         wb_v, wb_wr, wb_rd);
  end

  // Outputs are held low during reset regardless of the ID inputs (flush
  // would otherwise leak straight through to bubble_ex).
  always_comb begin
    stall_if_id        = rst_n & stall_int;
    bubble_ex          = rst_n & bubble_int;
    mux_Sel_RAW_ID_rs1 = rst_n & raw1_int;
    mux_Sel_RAW_ID_rs2 = rst_n & raw2_int;
    fwd_ex_rs1         = rst_n ? fwd1_int : FWD_NONE;
    fwd_ex_rs2         = rst_n ? fwd2_int : FWD_NONE;
  end

  // Advance the pipeline shadow; a bubble clears every EX field.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v   <= 1'b0; ex_wr  <= 1'b0; ex_ld <= 1'b0; ex_u1 <= 1'b0; ex_u2 <= 1'b0;
      ex_rd  <= '0;   ex_rs1 <= '0;   ex_rs2 <= '0;
      mem_v  <= 1'b0; mem_wr <= 1'b0; mem_ld <= 1'b0; mem_rd <= '0;
      wb_v   <= 1'b0; wb_wr  <= 1'b0; wb_rd  <= '0;
    end else begin
      wb_v   <= mem_v;
      wb_wr  <= mem_wr;
      wb_rd  <= mem_rd;
      mem_v  <= ex_v;
      mem_wr <= ex_wr;
      mem_ld <= ex_ld;
      mem_rd <= ex_rd;
      if (bubble_int || !id_valid) begin
        ex_v <= 1'b0; ex_wr <= 1'b0; ex_ld <= 1'b0; ex_u1 <= 1'b0; ex_u2 <= 1'b0;
        ex_rd <= '0;  ex_rs1 <= '0;  ex_rs2 <= '0;
      end else begin
        ex_v   <= 1'b1;
        ex_wr  <= id_reg_wr;
        ex_ld  <= id_is_load;
        ex_u1  <= id_use_rs1;
        ex_u2  <= id_use_rs2;
        ex_rd  <= id_rd;
        ex_rs1 <= id_rs1;
        ex_rs2 <= id_rs2;
      end
    end
  end

  // Saturating count of cycles in which IF/ID was actually held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_count <= '0;
    else if (stall_int && (stall_count != {CNT_W{1'b1}}))
      stall_count <= stall_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit. The driver applies one ID-stage
// vector per cycle and queues the hand-computed outputs; the monitor pops
// and compares on every falling edge. A second instance with a 2-bit
// counter sees the same stimulus to exercise saturation.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic       id_reg_wr = 1'b0, id_is_load = 1'b0, flush = 1'b0;

  logic        stall_if_id, bubble_ex, raw1, raw2;
  logic [1:0]  fwd1, fwd2;
  logic [15:0] stall_count;

  logic        s_stall, s_bubble, s_raw1, s_raw2;
  logic [1:0]  s_fwd1, s_fwd2;
  logic [1:0]  s_count;

  hazard_ctrl_unit #(.REG_ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_wr(id_reg_wr), .id_is_load(id_is_load), .flush(flush),
    .stall_if_id(stall_if_id), .bubble_ex(bubble_ex),
    .mux_Sel_RAW_ID_rs1(raw1), .mux_Sel_RAW_ID_rs2(raw2),
    .fwd_ex_rs1(fwd1), .fwd_ex_rs2(fwd2), .stall_count(stall_count)
  );

  hazard_ctrl_unit #(.REG_ADDR_W(5), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_wr(id_reg_wr), .id_is_load(id_is_load), .flush(flush),
    .stall_if_id(s_stall), .bubble_ex(s_bubble),
    .mux_Sel_RAW_ID_rs1(s_raw1), .mux_Sel_RAW_ID_rs2(s_raw2),
    .fwd_ex_rs1(s_fwd1), .fwd_ex_rs2(s_fwd2), .stall_count(s_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [7:0]  o;    // {stall, bubble, raw1, raw2, fwd1, fwd2}
    logic [15:0] cnt;
    logic [1:0]  sat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  logic [15:0] exp_cnt = '0;
  logic [1:0]  exp_sat = '0;

  // next ID instruction, applied by cyc() just after the rising edge
  logic       nv = 1'b0, nu1 = 1'b0, nu2 = 1'b0, nwr = 1'b0, nld = 1'b0;
  logic [4:0] nrs1 = '0, nrs2 = '0, nrd = '0;

  task automatic chk(input string tag, input string fld,
                     input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s actual=%0h required=%0h", tag, fld, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk(mon_e.name, "stall_if_id", 16'(stall_if_id), 16'(mon_e.o[7]));
      chk(mon_e.name, "bubble_ex",   16'(bubble_ex),   16'(mon_e.o[6]));
      chk(mon_e.name, "raw_rs1",     16'(raw1),        16'(mon_e.o[5]));
      chk(mon_e.name, "raw_rs2",     16'(raw2),        16'(mon_e.o[4]));
      chk(mon_e.name, "fwd_ex_rs1",  16'(fwd1),        16'(mon_e.o[3:2]));
      chk(mon_e.name, "fwd_ex_rs2",  16'(fwd2),        16'(mon_e.o[1:0]));
      chk(mon_e.name, "stall_count", stall_count,      mon_e.cnt);
      chk(mon_e.name, "sat_outputs",
          16'({s_stall, s_bubble, s_raw1, s_raw2, s_fwd1, s_fwd2}), 16'(mon_e.o));
      chk(mon_e.name, "sat_count",   16'(s_count),     16'(mon_e.sat));
    end
  end

  task automatic op_add(input int rd, input int rs1, input int rs2);
    nv = 1'b1; nu1 = 1'b1; nu2 = 1'b1; nwr = 1'b1; nld = 1'b0;
    nrd = 5'(rd); nrs1 = 5'(rs1); nrs2 = 5'(rs2);
  endtask

  task automatic op_lw(input int rd, input int rs1);
    nv = 1'b1; nu1 = 1'b1; nu2 = 1'b0; nwr = 1'b1; nld = 1'b1;
    nrd = 5'(rd); nrs1 = 5'(rs1); nrs2 = 5'd0;
  endtask

  task automatic op_nop();
    nv = 1'b0; nu1 = 1'b0; nu2 = 1'b0; nwr = 1'b0; nld = 1'b0;
    nrd = 5'd0; nrs1 = 5'd0; nrs2 = 5'd0;
  endtask

  task automatic cyc(input string name, input bit r, input bit fl,
                     input bit st, input bit bb, input bit r1, input bit r2,
                     input logic [1:0] f1, input logic [1:0] f2);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r; flush = fl;
    id_valid = nv; id_use_rs1 = nu1; id_use_rs2 = nu2; id_reg_wr = nwr;
    id_is_load = nld; id_rd = nrd; id_rs1 = nrs1; id_rs2 = nrs2;
    if (!r) begin
      exp_cnt = '0;
      exp_sat = '0;
    end
    e.name = name;
    e.o    = {st, bb, r1, r2, f1, f2};
    e.cnt  = exp_cnt;
    e.sat  = exp_sat;
    sb.push_back(e);
    if (r && st) begin
      if (exp_cnt != 16'hffff) exp_cnt = exp_cnt + 16'd1;
      if (exp_sat != 2'd3)     exp_sat = exp_sat + 2'd1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog sb_left=%0d required=0", sb.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 rst_n = 1'b0;
    // reset: flush and a live ID reading x3 must not leak through
    op_add(9, 3, 3);
    cyc("t1_init_rst0", 0, 1, 0,0,0,0, 2'b00, 2'b00);
    cyc("t1_init_rst1", 0, 1, 0,0,0,0, 2'b00, 2'b00);
    // WB->ID bypass
    op_add(5, 1, 2);  cyc("t2_c0", 1, 0, 0,0,0,0, 2'b00, 2'b00);
    op_nop();         cyc("t2_c1", 1, 0, 0,0,0,0, 2'b00, 2'b00);
    op_nop();         cyc("t2_c2", 1, 0, 0,0,0,0, 2'b00, 2'b00);
    op_add(9, 1, 5);  cyc("t2_wb_bypass", 1, 0, 0,0,0,1, 2'b00, 2'b00);
    op_nop();         cyc("t2_c4", 1, 0, 0,0,0,0, 2'b00, 2'b00);
    // load-use: one stall, then WB forward in EX
    op_lw(7, 1);      cyc("t3_load", 1, 0, 0,0,0,0, 2'b00, 2'b00);
    op_add(8, 7, 1);  cyc("t3_stall", 1, 0, 1,1,0,0, 2'b00, 2'b00);
    op_add(8, 7, 1);  cyc("t3_release", 1, 0, 0,0,0,0, 2'b00, 2'b00);
    op_nop();         cyc("t3_fwd_wb", 1, 0, 0,0,0,0, 2'b10, 2'b00);
    // MEM over WB priority, x0 never forwards or stalls
    op_add(3, 1, 2);  cyc("t4_c9", 1, 0, 0,0,0,0, 2'b00, 2'b00);
    op_add(3, 1, 2);  cyc("t4_c10", 1, 0, 0,0,0,0, 2'b00, 2'b00);
    op_add(4, 3, 0);  cyc("t4_c11", 1, 0, 0,0,0,0, 2'b00, 2'b00);
    op_nop();         cyc("t4_mem_prio", 1, 0, 0,0,0,0, 2'b01, 2'b00);
    op_add(0, 1, 2);  cyc("t4_c13", 1, 0, 0,0,0,0, 2'b00, 2'b00);
    op_add(6, 0, 0);  cyc("t4_c14", 1, 0, 0,0,0,0, 2'b00, 2'b00);
    op_nop();         cyc("t4_x0_mem", 1, 0, 0,0,0,0, 2'b00, 2'b00);
    op_add(10, 0, 0); cyc("t4_x0_wb_raw", 1, 0, 0,0,0,0, 2'b00, 2'b00);
    op_lw(0, 1);      cyc("t4_c17", 1, 0, 0,0,0,0, 2'b00, 2'b00);
    op_add(11, 0, 0); cyc("t4_x0_load", 1, 0, 0,0,0,0, 2'b00, 2'b00);
    op_nop();         cyc("t4_c19", 1, 0, 0,0,0,0, 2'b00, 2'b00);
    // flush wins over load-use; next EX is a bubble; load in MEM no stall
    op_lw(7, 1);      cyc("t5_load", 1, 0, 0,0,0,0, 2'b00, 2'b00);
    op_add(8, 7, 1);  cyc("t5_flush_luh", 1, 1, 0,1,0,0, 2'b00, 2'b00);
    op_add(12, 7, 8); cyc("t5_load_in_mem", 1, 0, 0,0,0,0, 2'b00, 2'b00);
    op_nop();         cyc("t5_ex_bubbled", 1, 0, 0,0,0,0, 2'b10, 2'b00);
    // five more load-use stalls: 16-bit count reaches 6, 2-bit holds at 3
    for (int i = 0; i < 5; i++) begin
      op_lw(13, 1);       cyc($sformatf("t6_load%0d", i), 1, 0, 0,0,0,0, 2'b00, 2'b00);
      op_add(14, 13, 13); cyc($sformatf("t6_stall%0d", i), 1, 0, 1,1,0,0, 2'b00, 2'b00);
      op_add(14, 13, 13); cyc($sformatf("t6_go%0d", i), 1, 0, 0,0,0,0, 2'b00, 2'b00);
      op_nop();           cyc($sformatf("t6_fwd%0d", i), 1, 0, 0,0,0,0, 2'b10, 2'b10);
    end
    // reset asserted in the cycle that would stall, with stale shadow state
    op_lw(3, 1);      cyc("t1_stale_load", 1, 0, 0,0,0,0, 2'b00, 2'b00);
    op_add(9, 3, 3);  cyc("t1_rst_midstall", 0, 1, 0,0,0,0, 2'b00, 2'b00);
    op_add(9, 3, 3);  cyc("t1_rst_hold", 0, 1, 0,0,0,0, 2'b00, 2'b00);
    op_add(9, 3, 3);  cyc("t1_release", 1, 0, 0,0,0,0, 2'b00, 2'b00);
    op_nop();         cyc("t1_shadow_empty", 1, 0, 0,0,0,0, 2'b00, 2'b00);
    op_nop();         cyc("end_idle", 1, 0, 0,0,0,0, 2'b00, 2'b00);
    @(negedge clk);
    #1;
    chk("end", "sb_left", 16'(sb.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
